// File: rtl/axi_write_ctrl_if.sv
// axi_write_ctrl_if: bundle of the M1/S0/S1 write-path control signals seen by the write sequencer
// Ports (signals):
//   AW : AWADDR_M1, AWLEN_M1, AWVALID_M1, AWREADY_M1, AWVALID_S0/S1, AWREADY_S0/S1, AW_sel
//   W  : W_state, WVALID_M1, WREADY_M1, WLAST_M1, WREADY_DEF
//   B  : BVALID_S0/S1, BRESP_S0/S1, BREADY_S0/S1, BVALID_M1, BRESP_M1, BREADY_M1
//   err: wlast_err, timeout_err (only with AXI_WRITE_TIMEOUT_EN)
// Modports: slave = the sequencer, master = the surrounding fabric/environment.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
interface axi_write_ctrl_if;
   logic [`AXI_ADDR_BITS-1:0] AWADDR_M1;
   logic [`AXI_LEN_BITS-1:0]  AWLEN_M1;
   logic       AWVALID_M1, AWREADY_M1;
   logic       AWVALID_S0, AWVALID_S1, AWREADY_S0, AWREADY_S1;
   logic [1:0] AW_sel, W_state;
   logic       WVALID_M1, WREADY_M1, WLAST_M1, WREADY_DEF;
   logic       BVALID_S0, BVALID_S1, BREADY_S0, BREADY_S1;
   logic [1:0] BRESP_S0, BRESP_S1, BRESP_M1;
   logic       BVALID_M1, BREADY_M1;
   logic       wlast_err;
`ifdef AXI_WRITE_TIMEOUT_EN
   logic       timeout_err;
`endif
   modport slave (
      input  AWADDR_M1, AWLEN_M1, AWVALID_M1, AWREADY_S0, AWREADY_S1,
             WVALID_M1, WREADY_M1, WLAST_M1, BVALID_S0, BVALID_S1, BRESP_S0, BRESP_S1, BREADY_M1,
      output AWREADY_M1, AWVALID_S0, AWVALID_S1, AW_sel, W_state, WREADY_DEF,
             BREADY_S0, BREADY_S1, BVALID_M1, BRESP_M1, wlast_err
`ifdef AXI_WRITE_TIMEOUT_EN
             , timeout_err
`endif
   );
   modport master (
      output AWADDR_M1, AWLEN_M1, AWVALID_M1, AWREADY_S0, AWREADY_S1,
             WVALID_M1, WREADY_M1, WLAST_M1, BVALID_S0, BVALID_S1, BRESP_S0, BRESP_S1, BREADY_M1,
      input  AWREADY_M1, AWVALID_S0, AWVALID_S1, AW_sel, W_state, WREADY_DEF,
             BREADY_S0, BREADY_S1, BVALID_M1, BRESP_M1, wlast_err
`ifdef AXI_WRITE_TIMEOUT_EN
             , timeout_err
`endif
   );
endinterface

// File: rtl/axi_write_ctrl.sv
// axi_write_ctrl: write-path sequencer (M1 -> S0/S1/decode-error) with one outstanding write
// Ports: ACLK clock; ARESETn async active-low reset; bus (axi_write_ctrl_if.slave) carrying
//   the AW decode/handshake, W_state data-mux select and beat tracking, B response routing,
//   wlast_err pulse. Optional macro AXI_WRITE_TIMEOUT_EN adds a 16-bit watchdog and timeout_err.
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
module axi_write_ctrl #(
   parameter logic [31:0] S0_BASE     = 32'h0000_0000,
   parameter logic [31:0] S1_BASE     = 32'h0001_0000,
   parameter int          REGION_BITS = 16
) (
   input logic             ACLK,
   input logic             ARESETn,
   axi_write_ctrl_if.slave bus
);
   localparam int AW = `AXI_ADDR_BITS;
   localparam int LW = `AXI_LEN_BITS;
   typedef enum logic [1:0] {ADDR, DATA, RESP} state_t;
   state_t        state, state_n;
   logic [1:0]    dec, sel_q;
   logic [LW-1:0] len_q, beat_cnt;
   logic          in_addr, in_data, in_resp, aw_hs, beat, b_hs, forced, tmo;
   assign in_addr = state == ADDR;
   assign in_data = state == DATA;
   assign in_resp = state == RESP;
   // slave codes: 1 = S0, 2 = S1, 3 = decode error
   assign dec = bus.AWADDR_M1[AW-1:REGION_BITS] == S0_BASE[AW-1:REGION_BITS] ? 2'd1 :
                bus.AWADDR_M1[AW-1:REGION_BITS] == S1_BASE[AW-1:REGION_BITS] ? 2'd2 : 2'd3;
   assign bus.AW_sel     = in_addr && bus.AWVALID_M1 ? dec : 2'd0;
   assign bus.AWVALID_S0 = in_addr && bus.AWVALID_M1 && dec == 2'd1;
   assign bus.AWVALID_S1 = in_addr && bus.AWVALID_M1 && dec == 2'd2;
   assign bus.AWREADY_M1 = in_addr && bus.AWVALID_M1 &&
                           (dec == 2'd1 ? bus.AWREADY_S0 : dec == 2'd2 ? bus.AWREADY_S1 : 1'b1);
   assign aw_hs = bus.AWREADY_M1;
   // sel_q and state are both registered, so W_state only changes on clock edges
   assign bus.W_state    = in_data ? sel_q : 2'd0;
   assign bus.WREADY_DEF = in_data && sel_q == 2'd3;
   assign beat = in_data && bus.WVALID_M1 && (bus.WREADY_M1 || bus.WREADY_DEF);
   assign bus.BVALID_M1 = in_resp && (forced || (sel_q == 2'd1 ? bus.BVALID_S0 :
                                                 sel_q == 2'd2 ? bus.BVALID_S1 : 1'b1));
   assign bus.BRESP_M1  = !in_resp ? 2'b00 : forced ? 2'b10 : sel_q == 2'd1 ? bus.BRESP_S0 :
                          sel_q == 2'd2 ? bus.BRESP_S1 : 2'b11;
   assign bus.BREADY_S0 = in_resp && !forced && sel_q == 2'd1 && bus.BREADY_M1;
   assign bus.BREADY_S1 = in_resp && !forced && sel_q == 2'd2 && bus.BREADY_M1;
   assign b_hs = bus.BVALID_M1 && bus.BREADY_M1;
   always_comb begin
      state_n = in_addr && aw_hs                 ? DATA :
                in_data && beat && bus.WLAST_M1  ? RESP :
                in_resp && b_hs                  ? ADDR : state;
      if (in_data && tmo) state_n = ADDR;
   end
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         state         <= ADDR;
         sel_q         <= 2'd0;
         len_q         <= '0;
         beat_cnt      <= '0;
         bus.wlast_err <= 1'b0;
      end else begin
         state         <= state_n;
         bus.wlast_err <= beat && (bus.WLAST_M1 ? beat_cnt != len_q : beat_cnt == len_q);
         if (aw_hs) begin
            sel_q    <= dec;
            len_q    <= bus.AWLEN_M1;
            beat_cnt <= '0;
         end else if (beat && !(&beat_cnt)) beat_cnt <= beat_cnt + LW'(1);
      end
`ifdef AXI_WRITE_TIMEOUT_EN
   logic [15:0] to_cnt;
   logic        to_q;
   // a timeout in RESP is remembered in to_q and answered locally with SLVERR
   assign forced = to_q;
   assign tmo    = (in_data || in_resp) && !to_q && !beat && !b_hs && to_cnt == 16'hFFFF;
   always_ff @(posedge ACLK or negedge ARESETn)
      if (!ARESETn) begin
         to_cnt          <= '0;
         to_q            <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.timeout_err <= tmo;
         to_q            <= state_n == RESP && (to_q || tmo);
         to_cnt          <= state_n == ADDR || beat || b_hs || to_q || tmo ? 16'd0 : to_cnt + 16'd1;
      end
`else
   assign forced = 1'b0;
   assign tmo    = 1'b0;
`endif
endmodule

// File: tb/tb_axi_write_ctrl.sv
// tb_axi_write_ctrl: table-driven self-checking bench for axi_write_ctrl with a B-response scoreboard
module tb_axi_write_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   logic [1:0] exp_q[$];
   always #5 clk = ~clk;
   axi_write_ctrl_if bus();
   axi_write_ctrl dut (.ACLK(clk), .ARESETn(rst_n), .bus(bus));
   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
      int          nb;
      int          dly;
      logic [1:0]  sel;
      logic [1:0]  bresp;
      int          stall;
      logic [1:0]  exp_bresp;
   } vec_t;
   vec_t vecs[6];
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chk_idle(input string nm);
      chk({nm, "_w_state"}, bus.W_state, 0);
      chk({nm, "_wready_def"}, bus.WREADY_DEF, 0);
      chk({nm, "_bvalid_m1"}, bus.BVALID_M1, 0);
      chk({nm, "_bready_s"}, {bus.BREADY_S0, bus.BREADY_S1}, 0);
      chk({nm, "_aw_out"}, {bus.AWREADY_M1, bus.AWVALID_S0, bus.AWVALID_S1, bus.AW_sel}, 0);
      chk({nm, "_wlast_err"}, bus.wlast_err, 0);
   endtask
   task automatic run_txn(input vec_t v);
      exp_q.push_back(v.exp_bresp);
      @(negedge clk);
      bus.AWADDR_M1 = v.addr;
      bus.AWLEN_M1 = v.len;
      bus.AWVALID_M1 = 1'b1;
      bus.BVALID_S0 = 1'b1;
      bus.BVALID_S1 = 1'b1;
      for (int c = 0; c <= v.dly; c++) begin
         bus.AWREADY_S0 = v.sel == 2'd1 && c == v.dly;
         bus.AWREADY_S1 = v.sel == 2'd2 && c == v.dly;
         #1;
         chk("aw_sel", bus.AW_sel, v.sel);
         chk("awready_m1", bus.AWREADY_M1, c == v.dly);
         chk("awvalid_s", {bus.AWVALID_S0, bus.AWVALID_S1}, {v.sel == 2'd1, v.sel == 2'd2});
         chk("bready_stray_aw", {bus.BREADY_S0, bus.BREADY_S1}, 0);
         @(negedge clk);
      end
      bus.AWVALID_M1 = 1'b0;
      bus.AWREADY_S0 = 1'b0;
      bus.AWREADY_S1 = 1'b0;
      #1;
      chk("w_state_after_aw", bus.W_state, v.sel);
      for (int b = 0; b < v.nb; b++) begin
         bus.WVALID_M1 = 1'b1;
         bus.WLAST_M1 = b == v.nb - 1;
         bus.WREADY_M1 = v.sel != 2'd3;
         #1;
         chk("w_state_data", bus.W_state, v.sel);
         chk("wready_def", bus.WREADY_DEF, v.sel == 2'd3);
         chk("bready_stray_w", {bus.BREADY_S0, bus.BREADY_S1}, 0);
         @(negedge clk);
         chk("wlast_err", bus.wlast_err, b == v.nb - 1 ? b != int'(v.len) : b == int'(v.len));
      end
      bus.WVALID_M1 = 1'b0;
      bus.WLAST_M1 = 1'b0;
      bus.WREADY_M1 = 1'b0;
      bus.BRESP_S0 = v.sel == 2'd1 ? v.bresp : 2'b01;
      bus.BRESP_S1 = v.sel == 2'd2 ? v.bresp : 2'b01;
      bus.AWVALID_M1 = 1'b1;
      for (int c = 0; c <= v.stall; c++) begin
         bus.BREADY_M1 = c == v.stall;
         #1;
         chk("w_state_resp", bus.W_state, 0);
         chk("bvalid_m1", bus.BVALID_M1, 1);
         chk("bready_s0", bus.BREADY_S0, v.sel == 2'd1 && c == v.stall);
         chk("bready_s1", bus.BREADY_S1, v.sel == 2'd2 && c == v.stall);
         chk("aw_stall", {bus.AWREADY_M1, bus.AWVALID_S0, bus.AWVALID_S1}, 0);
         if (c == v.stall) chk("bresp_m1", bus.BRESP_M1, exp_q.pop_front());
         @(negedge clk);
      end
      bus.BREADY_M1 = 1'b0;
      bus.AWVALID_M1 = 1'b0;
      bus.BVALID_S0 = 1'b0;
      bus.BVALID_S1 = 1'b0;
      #1;
      chk("bvalid_after", bus.BVALID_M1, 0);
      chk("wlast_err_once", bus.wlast_err, 0);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      vec_t r;
      {bus.AWADDR_M1, bus.AWLEN_M1, bus.AWVALID_M1, bus.AWREADY_S0, bus.AWREADY_S1} = '0;
      {bus.WVALID_M1, bus.WREADY_M1, bus.WLAST_M1, bus.BREADY_M1} = '0;
      {bus.BVALID_S0, bus.BVALID_S1, bus.BRESP_S0, bus.BRESP_S1} = '0;
      vecs[0] = '{32'h0000_0040, 8'd3, 4, 0, 2'd1, 2'b00, 0, 2'b00};
      vecs[1] = '{32'h0001_0100, 8'd0, 1, 3, 2'd2, 2'b01, 0, 2'b01};
      vecs[2] = '{32'h0005_0000, 8'd1, 2, 0, 2'd3, 2'b00, 0, 2'b11};
      vecs[3] = '{32'h0000_0080, 8'd3, 2, 0, 2'd1, 2'b10, 0, 2'b10};
      vecs[4] = '{32'h0000_0100, 8'd1, 3, 1, 2'd1, 2'b00, 1, 2'b00};
      vecs[5] = '{32'h0000_0200, 8'd0, 1, 0, 2'd1, 2'b00, 5, 2'b00};
      repeat (2) @(negedge clk);
      #1;
      chk_idle("reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) run_txn(vecs[i]);
      @(negedge clk);
      bus.AWADDR_M1 = 32'h0000_0300;
      bus.AWLEN_M1 = 8'd3;
      bus.AWVALID_M1 = 1'b1;
      bus.AWREADY_S0 = 1'b1;
      @(negedge clk);
      bus.AWVALID_M1 = 1'b0;
      bus.AWREADY_S0 = 1'b0;
      bus.WVALID_M1 = 1'b1;
      bus.WREADY_M1 = 1'b1;
      repeat (2) @(negedge clk);
      chk("mid_burst_w_state", bus.W_state, 1);
      rst_n = 1'b0;
      #1;
      chk_idle("mid_reset");
      bus.WVALID_M1 = 1'b0;
      bus.WREADY_M1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      r = '{32'h0001_0200, 8'd1, 2, 1, 2'd2, 2'b00, 0, 2'b00};
      run_txn(r);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
